// File: rtl/rv_test_ctrl_if.sv
// Bundle of start/status and per-hart monitor signals between a test harness and rv_test_ctrl.
// master = harness side, slave = controller side.
interface rv_test_ctrl_if #(
  parameter int NUM_HARTS = 1,
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32
);
  logic                      start;
  logic [NUM_HARTS-1:0]      halted;
  logic [NUM_HARTS*XLEN-1:0] a0_val;
  logic                      cpu_rst_n;
  logic                      busy;
  logic                      done;
  logic                      pass;
  logic                      timeout;
  logic [NUM_HARTS-1:0]      fail_mask;
  logic [CNT_W-1:0]          cycle_count;

  modport master (
    output start, halted, a0_val,
    input  cpu_rst_n, busy, done, pass, timeout, fail_mask, cycle_count
  );

  modport slave (
    input  start, halted, a0_val,
    output cpu_rst_n, busy, done, pass, timeout, fail_mask, cycle_count
  );
endinterface

// File: rtl/rv_test_ctrl.sv
// Test-run sequencer for RISC-V cores: holds cores in reset, runs them under a cycle budget,
// captures each hart's a0 on its first halt and reports pass / timeout / per-hart fail mask.
module rv_test_ctrl #(
  parameter int              NUM_HARTS      = 1,
  parameter int              XLEN           = 32,
  parameter int              RESET_CYCLES   = 2,
  parameter int              TIMEOUT_CYCLES = 100000,
  parameter int              CNT_W          = 32,
  parameter logic [XLEN-1:0] PASS_VALUE     = '0
) (
  input logic           i_clk,
  input logic           i_rst,
  rv_test_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | cores held in reset, waiting for start
  // RESET | cores held in reset for RESET_CYCLES cycles, run state cleared
  // RUN   | cores released, cycle budget counting, halts/a0 captured
  // CHECK | one cycle: compare captured a0 against PASS_VALUE
  // DONE  | results held, cores back in reset, start launches a new run

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_CHECK, S_DONE} state_t;

  state_t               r_state;
  logic [RW-1:0]        r_rst_cnt;
  logic [CNT_W-1:0]     r_cycle;
  logic [NUM_HARTS-1:0] r_seen;
  logic [NUM_HARTS-1:0] r_fail;
  logic [XLEN-1:0]      r_a0_cap [NUM_HARTS];
  logic                 r_cpu_rst_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_timeout;

  logic [NUM_HARTS-1:0] w_halt_any;
  logic [NUM_HARTS-1:0] w_fail;
  logic                 w_all_halted;
  logic                 w_expired;

  assign w_halt_any   = r_seen | bus.halted;
  assign w_all_halted = &w_halt_any;
  assign w_expired    = (r_cycle == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_fail = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      w_fail[i] = (r_a0_cap[i] != PASS_VALUE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rst_cnt   <= '0;
      r_cycle     <= '0;
      r_seen      <= '0;
      r_fail      <= '0;
      r_cpu_rst_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      for (int i = 0; i < NUM_HARTS; i++) r_a0_cap[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state     <= S_RESET;
            r_rst_cnt   <= RW'(RESET_CYCLES - 1);
            r_cycle     <= '0;
            r_seen      <= '0;
            r_fail      <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            for (int i = 0; i < NUM_HARTS; i++) r_a0_cap[i] <= '0;
          end
        end
        S_RESET: begin
          if (r_rst_cnt == '0) begin
            r_state     <= S_RUN;
            r_cpu_rst_n <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt - RW'(1);
          end
        end
        S_RUN: begin
          r_seen <= w_halt_any;
          // only the first halt of each hart is captured
          for (int i = 0; i < NUM_HARTS; i++) begin
            if (bus.halted[i] && !r_seen[i]) r_a0_cap[i] <= bus.a0_val[i*XLEN +: XLEN];
          end
          if (w_all_halted) begin
            r_state <= S_CHECK;
            r_cycle <= r_cycle + CNT_W'(1);
          end else if (w_expired) begin
            // counter stays on the last budgeted cycle when the run times out
            r_state     <= S_DONE;
            r_timeout   <= 1'b1;
            r_fail      <= ~w_halt_any;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cpu_rst_n <= 1'b0;
          end else begin
            r_cycle <= r_cycle + CNT_W'(1);
          end
        end
        S_CHECK: begin
          r_state     <= S_DONE;
          r_fail      <= w_fail;
          r_pass      <= (w_fail == '0);
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_cpu_rst_n <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_rst_n   = r_cpu_rst_n;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.timeout     = r_timeout;
  assign bus.fail_mask   = r_fail;
  assign bus.cycle_count = r_cycle;
endmodule

// File: tb/tb_rv_test_ctrl.sv
// Directed bench for rv_test_ctrl: two harts, 3-cycle core reset, 20-cycle run budget.
`timescale 1ns/1ps
module tb_rv_test_ctrl;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [14:0] st;
  logic [14:0] e;

  rv_test_ctrl_if #(.NUM_HARTS(2), .XLEN(32), .CNT_W(8)) bus ();

  rv_test_ctrl #(
    .NUM_HARTS(2), .XLEN(32), .RESET_CYCLES(3), .TIMEOUT_CYCLES(20),
    .CNT_W(8), .PASS_VALUE(32'd0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign st = {bus.cpu_rst_n, bus.busy, bus.done, bus.pass, bus.timeout,
               bus.fail_mask, bus.cycle_count};

  function automatic logic [14:0] exp_st(input logic rn, input logic b, input logic d,
                                         input logic p, input logic t,
                                         input logic [1:0] fm, input logic [7:0] cc);
    return {rn, b, d, p, t, fm, cc};
  endfunction

  // Pulses start; returns at the falling edge inside RUN cycle 0.
  task automatic launch();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.halted = '0; bus.a0_val = '0;
    repeat (2) @(negedge clk);
    e = exp_st(0, 0, 0, 0, 0, 2'b00, 8'd0);
    if (st !== e) begin $display("FAIL reset_values: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b0;
    if (st !== e) begin $display("FAIL start_under_rst: got %b want %b", st, e); n_err++; end
    n_vec++;
    @(negedge clk);
    if (st !== e) begin $display("FAIL idle_after_rst: got %b want %b", st, e); n_err++; end
    n_vec++;
  endtask

  task automatic test_reset_seq();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    e = exp_st(0, 1, 0, 0, 0, 2'b00, 8'd0);
    if (st !== e) begin $display("FAIL rstseq_c1: got %b want %b", st, e); n_err++; end
    n_vec++;
    @(negedge clk);
    if (st !== e) begin $display("FAIL rstseq_c2: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (st !== e) begin $display("FAIL rstseq_c3: got %b want %b", st, e); n_err++; end
    n_vec++;
    @(negedge clk);
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd0);
    if (st !== e) begin $display("FAIL rstseq_run0: got %b want %b", st, e); n_err++; end
    n_vec++;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = (c == 2 || c == 4);
    end
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd5);
    if (st !== e) begin $display("FAIL start_in_run_ignored: got %b want %b", st, e); n_err++; end
    n_vec++;
    @(negedge clk);
    bus.halted = 2'b11; bus.a0_val = '0;
    @(negedge clk);
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd7);
    if (st !== e) begin $display("FAIL rstseq_check: got %b want %b", st, e); n_err++; end
    n_vec++;
    @(negedge clk);
    e = exp_st(0, 0, 1, 1, 0, 2'b00, 8'd7);
    if (st !== e) begin $display("FAIL rstseq_done: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.halted = '0;
  endtask

  task automatic test_basic();
    launch();
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd0);
    if (st !== e) begin $display("FAIL basic_run0_cleared: got %b want %b", st, e); n_err++; end
    n_vec++;
    repeat (10) @(negedge clk);
    bus.halted = 2'b11; bus.a0_val = '0;
    @(negedge clk);
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd11);
    if (st !== e) begin $display("FAIL basic_check: got %b want %b", st, e); n_err++; end
    n_vec++;
    @(negedge clk);
    e = exp_st(0, 0, 1, 1, 0, 2'b00, 8'd11);
    if (st !== e) begin $display("FAIL basic_done: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.halted = 2'b00; bus.a0_val = {32'hDEAD_BEEF, 32'h1234_5678};
    repeat (3) @(negedge clk);
    if (st !== e) begin $display("FAIL basic_done_held: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.a0_val = '0;
  endtask

  task automatic test_capture();
    launch();
    repeat (5) @(negedge clk);
    bus.halted = 2'b01; bus.a0_val = '0;
    repeat (2) @(negedge clk);
    bus.a0_val[31:0] = 32'd7;
    repeat (2) @(negedge clk);
    bus.halted = 2'b11; bus.a0_val[63:32] = 32'd3;
    @(negedge clk);
    @(negedge clk);
    e = exp_st(0, 0, 1, 0, 0, 2'b10, 8'd10);
    if (st !== e) begin $display("FAIL capture_done: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.halted = '0; bus.a0_val = '0;
  endtask

  task automatic test_timeout();
    launch();
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd0);
    if (st !== e) begin $display("FAIL timeout_run0_cleared: got %b want %b", st, e); n_err++; end
    n_vec++;
    repeat (3) @(negedge clk);
    bus.halted = 2'b01;
    repeat (16) @(negedge clk);
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd19);
    if (st !== e) begin $display("FAIL timeout_last_run: got %b want %b", st, e); n_err++; end
    n_vec++;
    @(negedge clk);
    e = exp_st(0, 0, 1, 0, 1, 2'b10, 8'd19);
    if (st !== e) begin $display("FAIL timeout_done: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.halted = 2'b11;
    repeat (4) @(negedge clk);
    if (st !== e) begin $display("FAIL timeout_held: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.halted = '0;
  endtask

  task automatic test_boundary();
    launch();
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd0);
    if (st !== e) begin $display("FAIL boundary_run0_cleared: got %b want %b", st, e); n_err++; end
    n_vec++;
    repeat (2) @(negedge clk);
    bus.halted = 2'b01; bus.a0_val = '0;
    repeat (17) @(negedge clk);
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd19);
    if (st !== e) begin $display("FAIL boundary_last_run: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.halted = 2'b11;
    @(negedge clk);
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd20);
    if (st !== e) begin $display("FAIL boundary_check_taken: got %b want %b", st, e); n_err++; end
    n_vec++;
    @(negedge clk);
    e = exp_st(0, 0, 1, 1, 0, 2'b00, 8'd20);
    if (st !== e) begin $display("FAIL boundary_done: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.halted = '0;
  endtask

  task automatic test_mid_run_reset();
    launch();
    repeat (3) @(negedge clk);
    bus.halted = 2'b01; bus.a0_val[31:0] = 32'd9;
    repeat (5) @(negedge clk);
    e = exp_st(1, 1, 0, 0, 0, 2'b00, 8'd8);
    if (st !== e) begin $display("FAIL midrst_before: got %b want %b", st, e); n_err++; end
    n_vec++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.halted = '0; bus.a0_val = '0;
    e = exp_st(0, 0, 0, 0, 0, 2'b00, 8'd0);
    if (st !== e) begin $display("FAIL midrst_values: got %b want %b", st, e); n_err++; end
    n_vec++;
    @(negedge clk);
    if (st !== e) begin $display("FAIL midrst_idle: got %b want %b", st, e); n_err++; end
    n_vec++;
    launch();
    bus.halted = 2'b10; bus.a0_val[63:32] = 32'd5;
    repeat (3) @(negedge clk);
    bus.halted = 2'b11; bus.a0_val = '0;
    repeat (2) @(negedge clk);
    e = exp_st(0, 0, 1, 0, 0, 2'b10, 8'd4);
    if (st !== e) begin $display("FAIL midrst_new_run: got %b want %b", st, e); n_err++; end
    n_vec++;
    bus.halted = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; bus.start = 1'b0; bus.halted = '0; bus.a0_val = '0;
    test_reset();
    test_reset_seq();
    test_basic();
    test_capture();
    test_timeout();
    test_boundary();
    test_mid_run_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rv_test_ctrl.md
RV_TEST_CTRL -- requirements
Module: rv_test_ctrl

Interface
REQ-001 Parameter NUM_HARTS, default 1: number of monitored cores, 1..8.
REQ-002 Parameter XLEN, default 32: width of each hart's result register (x10/a0).
REQ-003 Parameter RESET_CYCLES, default 2: cycles the cores are held in reset per run, >=1.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000: run-phase cycle budget, >=2.
REQ-005 Parameter CNT_W, default 32: cycle counter width, 2^CNT_W > TIMEOUT_CYCLES.
REQ-006 Parameter PASS_VALUE, default 0: required a0 value for a passing hart.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle request to begin a run; sampled in IDLE and DONE only.
REQ-010 halted  in  NUM_HARTS  per-hart halt indication; bit i from hart i.
REQ-011 a0_val  in  NUM_HARTS*XLEN  hart i's x10 at bits [i*XLEN +: XLEN].
REQ-012 cpu_rst_n  out  1  active-low reset driven to all cores.
REQ-013 busy  out  1  high in RESET, RUN, CHECK.
REQ-014 done  out  1  high while in DONE.
REQ-015 pass  out  1  valid when done: all harts halted with a0 == PASS_VALUE.
REQ-016 timeout  out  1  valid when done: budget expired before all harts halted.
REQ-017 fail_mask  out  NUM_HARTS  valid when done: bit i set if hart i did not pass.
REQ-018 cycle_count  out  CNT_W  RUN-phase cycles elapsed; frozen outside RUN.

Function
REQ-019 FSM states SHALL be IDLE, RESET, RUN, CHECK, DONE.
REQ-020 IDLE: cpu_rst_n=0; start=1 -> RESET next cycle.
REQ-021 RESET: cpu_rst_n=0 for exactly RESET_CYCLES cycles, then RUN; entry clears cycle_count, halted_seen, captured a0, pass, timeout, fail_mask.
REQ-022 RUN: cpu_rst_n=1; cycle_count increments by 1 each RUN cycle, first RUN cycle sees 0.
REQ-023 RUN: halted_seen[i] SHALL be sticky; on the first cycle halted[i]=1, a0_val slice i is captured and not overwritten later in the run.
REQ-024 RUN: when (halted_seen | halted) is all ones -> CHECK next cycle.
REQ-025 RUN: if cycle_count == TIMEOUT_CYCLES-1 and not all halted -> DONE with timeout=1, pass=0, fail_mask = ~(halted_seen | halted).
REQ-026 All-halted and timeout in the same cycle: all-halted wins (-> CHECK, timeout=0).
REQ-027 CHECK (one cycle): fail_mask[i] = (captured a0[i] != PASS_VALUE); pass = (fail_mask == 0); -> DONE.
REQ-028 Latency: last hart halting in RUN cycle N -> done=1 two cycles later.
REQ-029 DONE: cpu_rst_n=0; done, pass, timeout, fail_mask, cycle_count held stable; start=1 -> RESET (new run).
REQ-030 start while busy SHALL be ignored.
REQ-031 halted and a0_val SHALL be ignored outside RUN.
REQ-032 cycle_count SHALL NOT wrap within a run (guaranteed by REQ-005).

Reset
REQ-033 rst=1 SHALL force IDLE on the next edge from any state, including mid-RUN.
REQ-034 Reset values: cpu_rst_n=0, busy=0, done=0, pass=0, timeout=0, fail_mask=0, cycle_count=0, halted_seen=0.

Verification
REQ-035 NUM_HARTS=1, start; hart halts in RUN cycle 10 with a0=0 -> done at RUN cycle 12, pass=1, fail_mask=0, cycle_count=11.
REQ-036 NUM_HARTS=2; hart0 halts cycle 5 a0=0, later a0 changes to 7, hart1 halts cycle 9 a0=3 -> pass=0, fail_mask=2'b10 (hart0 capture unaffected).
REQ-037 TIMEOUT_CYCLES=20, hart never halts -> done after 20 RUN cycles, timeout=1, pass=0, fail_mask=1, cycle_count=19.
REQ-038 TIMEOUT_CYCLES=20, halt at cycle_count=19 -> CHECK taken, timeout=0, pass per a0.
REQ-039 RESET_CYCLES=3: cpu_rst_n low exactly 3 cycles after start; start pulses during RUN ignored.
REQ-040 rst asserted mid-RUN -> IDLE next cycle, all outputs at reset values; then start runs a clean new test.
